// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, instruction-cache frame and cache FSM state.
// Frame tags are stored zero-extended to 30 bits so one struct serves every cache depth.
// No timing or backpressure: types and one pure helper only.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic {
        LOOKUP = 1'b0,
        MISS   = 1'b1
    } icache_state_t;

    typedef struct packed {
        logic        valid;
        logic [29:0] tag;
        word_t       data;
    } icache_frame_t;

    function automatic word_t word_align(input word_t addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/icache.sv
// Direct-mapped one-word instruction cache; optional counters under ICACHE_STATS_EN.
// Latency: hits are combinational (0 cycles); a miss costs memory access cycles + 1.
// Backpressure: iwait high holds the cache in MISS; requests changing meanwhile do not abort the fill.
module icache
    import cpu_types_pkg::*;
#(
    parameter int ICACHE_SETS = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    input  logic        iflush,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    localparam int IDX  = $clog2(ICACHE_SETS);
    localparam int TAGW = 30 - IDX;

    icache_frame_t frames [ICACHE_SETS];
    icache_state_t state;
    word_t         miss_addr;

    logic [IDX-1:0] req_idx;
    logic [IDX-1:0] miss_idx;
    logic [29:0]    req_tag;
    logic [29:0]    miss_tag;
    icache_frame_t  hit_frame;
    logic           lookup_miss;

    assign req_idx  = imemaddr[IDX+1:2];
    assign req_tag  = 30'(imemaddr[31:IDX+2]);
    assign miss_idx = miss_addr[IDX+1:2];
    assign miss_tag = 30'(miss_addr[31:IDX+2]);

    always_comb begin
        hit_frame = frames[req_idx];
        ihit      = !RST && (state == LOOKUP) && imemREN && !iflush
                    && hit_frame.valid && (hit_frame.tag == req_tag);
        imemload  = ihit ? hit_frame.data : '0;
        iREN      = !RST && (state == MISS);
        iaddr     = iREN ? miss_addr : '0;
    end

    assign lookup_miss = (state == LOOKUP) && imemREN && !ihit && !iflush;

    // Tag and data are left unreset; only the valid bits gate the lookup.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= LOOKUP;
            miss_addr <= '0;
            for (int i = 0; i < ICACHE_SETS; i++) frames[i].valid <= 1'b0;
        end else if (iflush) begin
            state <= LOOKUP;
            for (int i = 0; i < ICACHE_SETS; i++) frames[i].valid <= 1'b0;
        end else begin
            case (state)
                LOOKUP: begin
                    if (lookup_miss) begin
                        state     <= MISS;
                        miss_addr <= word_align(imemaddr);
                    end
                end
                MISS: begin
                    if (!iwait) begin
                        frames[miss_idx] <= '{valid: 1'b1, tag: miss_tag, data: iload};
                        state            <= LOOKUP;
                    end
                end
                default: state <= LOOKUP;
            endcase
        end
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (ihit)        hit_count  <= hit_count + 32'd1;
            if (lookup_miss) miss_count <= miss_count + 32'd1;
        end
    end
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

    logic unused_tagw;
    assign unused_tagw = (TAGW > 0);

endmodule

// File: tb/tb_icache.sv
// Bench for icache: directed scenarios with literal expectations, then random traffic
// compared every cycle against a transaction-level cache model.
module tb_icache;

    localparam int SETS = 16;

    logic        CLK = 1'b0;
    logic        RST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iflush;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    icache #(.ICACHE_SETS(SETS)) dut (
        .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr),
        .ihit(ihit), .imemload(imemload), .iflush(iflush), .iREN(iREN),
        .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Model: what each set currently holds (full word address + data), plus an outstanding miss.
    bit          m_valid [SETS];
    logic [31:0] m_waddr [SETS];
    logic [31:0] m_data  [SETS];
    bit          m_pending;
    logic [31:0] m_paddr;
    logic [31:0] m_hits;
    logic [31:0] m_misses;

    logic        s_ihit;
    logic [31:0] s_load;
    logic        s_iren;
    logic [31:0] s_iaddr;
    logic [31:0] s_hitc;
    logic [31:0] s_missc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int set_of(input logic [31:0] a);
        return int'((a >> 2) % SETS);
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Starts at a falling edge, drives inputs, compares, then advances one clock.
    task automatic step(input bit rst, input bit ren, input logic [31:0] addr,
                        input bit flush, input bit wt, input logic [31:0] ld);
        bit          e_hit;
        logic [31:0] e_load;
        bit          e_iren;
        logic [31:0] wa;
        int          s;
        RST = rst; imemREN = ren; imemaddr = addr; iflush = flush; iwait = wt; iload = ld;
        #1;
        wa     = addr & 32'hFFFF_FFFC;
        s      = set_of(addr);
        e_hit  = !rst && !m_pending && ren && !flush && m_valid[s] && (m_waddr[s] == wa);
        e_load = e_hit ? m_data[s] : 32'h0;
        e_iren = !rst && m_pending;
        chk("ihit", {31'h0, ihit}, {31'h0, e_hit});
        chk("imemload", imemload, e_load);
        chk("iREN", {31'h0, iREN}, {31'h0, e_iren});
        chk("iaddr", iaddr, e_iren ? m_paddr : 32'h0);
`ifdef ICACHE_STATS_EN
        if (!rst) begin
            chk("hit_count", hit_count, m_hits);
            chk("miss_count", miss_count, m_misses);
        end
`else
        if (!rst) begin
            chk("hit_count", hit_count, 32'h0);
            chk("miss_count", miss_count, 32'h0);
        end
`endif
        s_ihit = ihit; s_load = imemload; s_iren = iREN; s_iaddr = iaddr;
        s_hitc = hit_count; s_missc = miss_count;
        @(posedge CLK);
        if (rst) begin
            m_pending = 0; m_paddr = 0; m_hits = 0; m_misses = 0;
            for (int i = 0; i < SETS; i++) m_valid[i] = 0;
        end else begin
            if (e_hit) m_hits++;
            if (flush) begin
                m_pending = 0;
                for (int i = 0; i < SETS; i++) m_valid[i] = 0;
            end else if (m_pending) begin
                if (!wt) begin
                    m_valid[set_of(m_paddr)] = 1;
                    m_waddr[set_of(m_paddr)] = m_paddr;
                    m_data[set_of(m_paddr)]  = ld;
                    m_pending = 0;
                end
            end else if (ren && !e_hit) begin
                m_pending = 1;
                m_paddr   = wa;
                m_misses++;
            end
        end
        @(negedge CLK);
    endtask

    task automatic fill(input logic [31:0] addr, input logic [31:0] data);
        step(0, 1, addr, 0, 1, 0);
        step(0, 1, addr, 0, 0, data);
    endtask

    initial begin
        bit          rst, ren, fl, wt;
        logic [31:0] a;
        m_pending = 0; m_paddr = 0; m_hits = 0; m_misses = 0;
        for (int i = 0; i < SETS; i++) begin
            m_valid[i] = 0; m_waddr[i] = 0; m_data[i] = 0;
        end
        RST = 1; imemREN = 0; imemaddr = 0; iflush = 0; iwait = 1; iload = 0;
        @(negedge CLK);

        // Reset state.
        step(1, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        chk("rst_ihit", {31'h0, s_ihit}, 32'h0);
        chk("rst_iREN", {31'h0, s_iren}, 32'h0);
        chk("rst_iaddr", s_iaddr, 32'h0);
        chk("rst_hitc", s_hitc, 32'h0);

        // Cold miss: four cycles of iREN, then the hit.
        step(0, 1, 32'h40, 0, 1, 0);
        chk("cold_lookup_ihit", {31'h0, s_ihit}, 32'h0);
        for (int k = 0; k < 4; k++) begin
            step(0, 1, 32'h40, 0, (k < 3), (k == 3) ? 32'hDEAD_BEEF : 32'h0);
            chk("cold_iREN", {31'h0, s_iren}, 32'h1);
            chk("cold_iaddr", s_iaddr, 32'h40);
        end
        step(0, 1, 32'h40, 0, 1, 0);
        chk("cold_hit", {31'h0, s_ihit}, 32'h1);
        chk("cold_load", s_load, 32'hDEAD_BEEF);
`ifdef ICACHE_STATS_EN
        chk("cold_missc", s_missc, 32'h1);
`endif

        // Conflict: 0x80 evicts 0x40 in a 16-set cache.
        fill(32'h40, 32'h1111_1111);
        fill(32'h80, 32'h2222_2222);
        step(0, 1, 32'h40, 0, 1, 0);
        chk("conflict_miss", {31'h0, s_ihit}, 32'h0);
        step(0, 1, 32'h40, 0, 0, 32'h1111_1111);
        chk("conflict_iaddr", s_iaddr, 32'h40);

        // Address change during a miss does not redirect the fill.
        step(0, 0, 0, 1, 1, 0);
        step(0, 1, 32'h40, 0, 1, 0);
        step(0, 1, 32'h44, 0, 1, 0);
        chk("midmiss_iaddr", s_iaddr, 32'h40);
        step(0, 1, 32'h44, 0, 0, 32'h3333_3333);
        chk("midmiss_iaddr2", s_iaddr, 32'h40);
        step(0, 1, 32'h44, 0, 1, 0);
        chk("midmiss_44_miss", {31'h0, s_ihit}, 32'h0);
        step(0, 1, 32'h44, 0, 0, 32'h4444_4444);
        chk("midmiss_44_iaddr", s_iaddr, 32'h44);
        step(0, 1, 32'h40, 0, 1, 0);
        chk("midmiss_40_load", s_load, 32'h3333_3333);

        // Flush during a hit, then flush coinciding with a fill.
        step(0, 1, 32'h40, 1, 1, 0);
        chk("flush_ihit", {31'h0, s_ihit}, 32'h0);
        step(0, 1, 32'h40, 0, 1, 0);
        chk("flush_after_miss", {31'h0, s_ihit}, 32'h0);
        step(0, 1, 32'h40, 1, 0, 32'h5555_5555);
        step(0, 1, 32'h40, 0, 1, 0);
        chk("flush_fill_dropped", {31'h0, s_ihit}, 32'h0);
        step(0, 1, 32'h40, 0, 0, 32'h6666_6666);

        // Reset in the middle of a miss.
        fill(32'h48, 32'h7777_7777);
        step(0, 1, 32'h4C, 0, 1, 0);
        step(1, 1, 32'h4C, 0, 1, 0);
        step(0, 0, 32'h48, 0, 1, 0);
        chk("rstmid_iREN", {31'h0, s_iren}, 32'h0);
        chk("rstmid_missc", s_missc, 32'h0);
        chk("rstmid_hitc", s_hitc, 32'h0);
        step(0, 1, 32'h48, 0, 1, 0);
        chk("rstmid_read_miss", {31'h0, s_ihit}, 32'h0);
        step(0, 1, 32'h48, 0, 0, 32'h8888_8888);

        // Random traffic over a small address pool so sets collide and hit.
        for (int n = 0; n < 4000; n++) begin
            rst = ($urandom_range(0, 299) == 0);
            fl  = ($urandom_range(0, 39) == 0);
            ren = ($urandom_range(0, 9) < 7);
            wt  = ($urandom_range(0, 9) < 6);
            a   = {($urandom_range(0, 3) == 0) ? 24'h00_1000 : 24'h0, 8'($urandom)};
            step(rst, ren, a, fl, wt, wt ? $urandom : mem_word(m_paddr));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 Parameter: ICACHE_SETS, 16, number of direct-mapped one-word frames; power of two, 2..256.
REQ-002 CLK  input  1  rising-edge clock.
REQ-003 RST  input  1  reset; synchronous, active-high.
REQ-004 imemREN  input  1  datapath fetch request.
REQ-005 imemaddr  input  32  fetch byte address; bits [1:0] ignored.
REQ-006 ihit  output  1  imemload valid this cycle.
REQ-007 imemload  output  32  fetched instruction.
REQ-008 iflush  input  1  invalidate all frames.
REQ-009 iREN  output  1  read request to memory control.
REQ-010 iaddr  output  32  word-aligned miss address to memory control.
REQ-011 iwait  input  1  memory control stall; low means iload is valid.
REQ-012 iload  input  32  fill data from memory control.
REQ-013 hit_count  output  32  hits counted since reset; present only per REQ-030.
REQ-014 miss_count  output  32  misses counted since reset; present only per REQ-030.

Function
REQ-015 Address split: offset = [1:0]; index = [IDX+1:2] with IDX = log2(ICACHE_SETS); tag = [31:IDX+2].
REQ-016 Each frame holds: valid (1 bit), tag, and data (32 bits).
REQ-017 FSM has two states, LOOKUP and MISS.
REQ-018 In LOOKUP: ihit = imemREN & valid[index] & (tag match), combinational with zero-cycle latency; imemload = frame data whenever ihit = 1, and 0 otherwise.
REQ-019 LOOKUP -> MISS when imemREN=1 and ihit=0 and iflush=0; on that edge the cache latches the word-aligned address into miss_addr.
REQ-020 In MISS: iREN=1, iaddr=miss_addr, ihit=0; all other cycles: iREN=0, iaddr=0.
REQ-021 In MISS, when iwait=0 the frame at miss_addr index is written with {1, miss_addr tag, iload}, and the FSM returns to LOOKUP on the same edge.
REQ-022 The refetch hits in the cycle after the fill, so the total miss latency is (RAM access cycles + 1).
REQ-023 Changes to imemaddr or imemREN during MISS do not abort the fill; the latched miss_addr completes.
REQ-024 iflush=1 in any state clears every valid bit on the next edge and forces LOOKUP; a fill arriving in the same cycle is discarded; ihit is forced to 0 during the flush cycle.
REQ-025 A fill overwrites a conflicting frame unconditionally; a fill never writes any other frame.

Reset
REQ-026 RST=1 at an edge forces: state = LOOKUP, all valid bits = 0, and miss_addr = 0, regardless of the current state, including mid-miss.
REQ-027 During and after reset, before any request: ihit=0, imemload=0, iREN=0, iaddr=0, hit_count=0, and miss_count=0.
REQ-028 Tag and data arrays are not reset.

Configuration
REQ-029 The macro ICACHE_STATS_EN controls the statistics counters.
REQ-030 With ICACHE_STATS_EN defined, hit_count increments on each cycle with ihit=1. In the same configuration, miss_count increments on each LOOKUP->MISS transition. Both counters wrap at 2^32, and neither is cleared by iflush.
REQ-031 Without ICACHE_STATS_EN defined, hit_count and miss_count are tied to 0 and no counter flops exist.

Structure
REQ-032 The icache_frame_t struct {valid, tag, data} and the icache_state_t enum belong in cpu_types_pkg. word_t is reused from the same package.
REQ-033 There is no sub-module; the frame array, FSM, and counters live in icache.

Verification
REQ-034 Cold miss: imemREN=1 and imemaddr=0x40, with iwait high for 3 cycles and then low with iload=0xDEADBEEF. Required response: iREN=1 and iaddr=0x40 for 4 cycles; the next cycle gives ihit=1 and imemload=0xDEADBEEF; miss_count=1.
REQ-035 Conflict: fill 0x40 (0x11111111), then fill 0x80 (0x22222222), then read 0x40 (ICACHE_SETS=16). Required response: the read of 0x40 misses again and iaddr=0x40.
REQ-036 Address change mid-miss: a miss on 0x40, with imemaddr switched to 0x44 while iwait=1. Required response: iaddr stays 0x40 and the frame for 0x40 is filled. The request for 0x44 then misses and iaddr=0x44.
REQ-037 Flush: fill 0x40, then iflush=1 for one cycle during a hit. Required response: ihit=0 in the flush cycle, and the following access to 0x40 misses. With iflush=1 during MISS as iwait falls, the frame stays invalid.
REQ-038 Reset mid-miss: RST=1 while in MISS. Required response: iREN=0 on the next cycle, and all reads miss. With ICACHE_STATS_EN defined, both counters read 0.
